// File: rtl/bsg_cycle_counter.sv
// Free-running cycle counter with a sticky overflow flag; BSG_CYCLE_COUNTER_SATURATE_EN holds at all-ones instead of wrapping.
// Latency: one cycle, with both outputs registered. Backpressure: none, because the counter advances on every cycle that is not in reset.
// Reset is synchronous and active-low, and it takes precedence over increment, wrap and saturation.
module bsg_cycle_counter #(
    parameter int          width_p    = 32,
    parameter logic [63:0] init_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    output logic [width_p-1:0] ctr_r_o,
    output logic               overflow_o
);

    logic [width_p-1:0] r_ctr;
    logic               r_overflow;
    logic [width_p:0]   w_sum;
    logic               w_carry;
    logic [width_p-1:0] w_ctr_nxt;

    // The carry-out of the sum only marks overflow; the count itself stays width_p bits.
    assign w_sum   = {1'b0, r_ctr} + {{width_p{1'b0}}, 1'b1};
    assign w_carry = w_sum[width_p];

`ifdef BSG_CYCLE_COUNTER_SATURATE_EN
    assign w_ctr_nxt = w_carry ? r_ctr : w_sum[width_p-1:0];
`else
    assign w_ctr_nxt = w_sum[width_p-1:0];
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ctr      <= init_val_p[width_p-1:0];
            r_overflow <= 1'b0;
        end else begin
            r_ctr      <= w_ctr_nxt;
            r_overflow <= r_overflow | w_carry;
        end
    end

    assign ctr_r_o    = r_ctr;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_bsg_cycle_counter.sv
// Bench for bsg_cycle_counter: several parameterisations driven from one clock, checked against a scoreboard queue.
module tb_bsg_cycle_counter;

    typedef struct packed {
        logic [63:0] ctr;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0, rst_e = 1'b0, rst_s = 1'b0;
    logic [7:0]  ctr_a, ctr_b;
    logic [3:0]  ctr_c, ctr_s;
    logic [0:0]  ctr_d;
    logic [15:0] ctr_e;
    logic        ovf_a, ovf_b, ovf_c, ovf_d, ovf_e, ovf_s;

    bsg_cycle_counter #(.width_p(8),  .init_val_p(64'h0))  dut_a (.clk_i(clk), .reset_n_i(rst_a), .ctr_r_o(ctr_a), .overflow_o(ovf_a));
    bsg_cycle_counter #(.width_p(8),  .init_val_p(64'hFD)) dut_b (.clk_i(clk), .reset_n_i(rst_b), .ctr_r_o(ctr_b), .overflow_o(ovf_b));
    bsg_cycle_counter #(.width_p(4),  .init_val_p(64'h0))  dut_c (.clk_i(clk), .reset_n_i(rst_c), .ctr_r_o(ctr_c), .overflow_o(ovf_c));
    bsg_cycle_counter #(.width_p(1),  .init_val_p(64'h0))  dut_d (.clk_i(clk), .reset_n_i(rst_d), .ctr_r_o(ctr_d), .overflow_o(ovf_d));
    bsg_cycle_counter #(.width_p(16), .init_val_p(64'h0))  dut_e (.clk_i(clk), .reset_n_i(rst_e), .ctr_r_o(ctr_e), .overflow_o(ovf_e));
    bsg_cycle_counter #(.width_p(4),  .init_val_p(64'hE))  dut_s (.clk_i(clk), .reset_n_i(rst_s), .ctr_r_o(ctr_s), .overflow_o(ovf_s));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{ctr: 64'd0, ovf: 1'b0});
            step();
            e = sb.pop_front();
            total++;
            if (ctr_a !== e.ctr[7:0] || ovf_a !== e.ovf) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got ctr=%0h ovf=%b want ctr=%0h ovf=%b", i, ctr_a, ovf_a, e.ctr[7:0], e.ovf);
            end
        end
        rst_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sb.push_back('{ctr: 64'(i), ovf: 1'b0});
            step();
            e = sb.pop_front();
            total++;
            if (ctr_a !== e.ctr[7:0] || ovf_a !== e.ovf) begin
                bad++;
                $display("FAIL count[%0d]: got ctr=%0h ovf=%b want ctr=%0h ovf=%b", i, ctr_a, ovf_a, e.ctr[7:0], e.ovf);
            end
        end
    endtask

    task automatic test_init_wrap();
        logic [7:0] m_ctr;
        logic       m_ovf;
        m_ctr = 8'hFD;
        m_ovf = 1'b0;
        total++;
        if (ctr_b !== 8'hFD || ovf_b !== 1'b0) begin
            bad++;
            $display("FAIL init_reset: got ctr=%0h ovf=%b want ctr=fd ovf=0", ctr_b, ovf_b);
        end
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (m_ctr == 8'hFF) m_ovf = 1'b1;
            m_ctr = m_ctr + 8'd1;
            sb.push_back('{ctr: {56'd0, m_ctr}, ovf: m_ovf});
            step();
            e = sb.pop_front();
            total++;
            if (ctr_b !== e.ctr[7:0] || ovf_b !== e.ovf) begin
                bad++;
                $display("FAIL init_wrap[%0d]: got ctr=%0h ovf=%b want ctr=%0h ovf=%b", i, ctr_b, ovf_b, e.ctr[7:0], e.ovf);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst_c = 1'b1;
        // Wrap once, then count to 9, so that the reset has a set overflow flag to clear.
        for (int i = 1; i <= 25; i++) begin
            sb.push_back('{ctr: 64'(i % 16), ovf: (i >= 16)});
            step();
            e = sb.pop_front();
            if (i == 15 || i == 16 || i == 25) begin
                total++;
                if (ctr_c !== e.ctr[3:0] || ovf_c !== e.ovf) begin
                    bad++;
                    $display("FAIL midcount[%0d]: got ctr=%0h ovf=%b want ctr=%0h ovf=%b", i, ctr_c, ovf_c, e.ctr[3:0], e.ovf);
                end
            end
        end
        #2 rst_c = 1'b0;
        #1;
        total++;
        if (ctr_c !== 4'd9 || ovf_c !== 1'b1) begin
            bad++;
            $display("FAIL reset_async: got ctr=%0h ovf=%b want ctr=9 ovf=1", ctr_c, ovf_c);
        end
        sb.push_back('{ctr: 64'd0, ovf: 1'b0});
        step();
        rst_c = 1'b1;
        e = sb.pop_front();
        total++;
        if (ctr_c !== e.ctr[3:0] || ovf_c !== e.ovf) begin
            bad++;
            $display("FAIL mid_reset: got ctr=%0h ovf=%b want ctr=%0h ovf=%b", ctr_c, ovf_c, e.ctr[3:0], e.ovf);
        end
        for (int i = 1; i <= 2; i++) begin
            sb.push_back('{ctr: 64'(i), ovf: 1'b0});
            step();
            e = sb.pop_front();
            total++;
            if (ctr_c !== e.ctr[3:0] || ovf_c !== e.ovf) begin
                bad++;
                $display("FAIL resume[%0d]: got ctr=%0h ovf=%b want ctr=%0h ovf=%b", i, ctr_c, ovf_c, e.ctr[3:0], e.ovf);
            end
        end
    endtask

    task automatic test_width1();
        rst_d = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sb.push_back('{ctr: 64'(i % 2), ovf: (i >= 2)});
            step();
            e = sb.pop_front();
            total++;
            if (ctr_d !== e.ctr[0:0] || ovf_d !== e.ovf) begin
                bad++;
                $display("FAIL width1[%0d]: got ctr=%0h ovf=%b want ctr=%0h ovf=%b", i, ctr_d, ovf_d, e.ctr[0:0], e.ovf);
            end
        end
    endtask

    task automatic test_top_value();
        rst_s = 1'b1;
`ifdef BSG_CYCLE_COUNTER_SATURATE_EN
        sb.push_back('{ctr: 64'hF, ovf: 1'b0});
        sb.push_back('{ctr: 64'hF, ovf: 1'b1});
        sb.push_back('{ctr: 64'hF, ovf: 1'b1});
        sb.push_back('{ctr: 64'hF, ovf: 1'b1});
`else
        sb.push_back('{ctr: 64'hF, ovf: 1'b0});
        sb.push_back('{ctr: 64'h0, ovf: 1'b1});
        sb.push_back('{ctr: 64'h1, ovf: 1'b1});
        sb.push_back('{ctr: 64'h2, ovf: 1'b1});
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            e = sb.pop_front();
            total++;
            if (ctr_s !== e.ctr[3:0] || ovf_s !== e.ovf) begin
                bad++;
                $display("FAIL top_value[%0d]: got ctr=%0h ovf=%b want ctr=%0h ovf=%b", i, ctr_s, ovf_s, e.ctr[3:0], e.ovf);
            end
        end
    endtask

    task automatic test_long_run();
        rst_e = 1'b1;
        for (int i = 1; i <= 70000; i++) begin
            if (i == 65535 || i == 65536 || i == 70000) begin
                sb.push_back('{ctr: 64'(i % 65536), ovf: (i >= 65536)});
            end
            step();
            if (i == 65535 || i == 65536 || i == 70000) begin
                e = sb.pop_front();
                total++;
                if (ctr_e !== e.ctr[15:0] || ovf_e !== e.ovf) begin
                    bad++;
                    $display("FAIL long_run[%0d]: got ctr=%0d ovf=%b want ctr=%0d ovf=%b", i, ctr_e, ovf_e, e.ctr[15:0], e.ovf);
                end
            end
        end
    endtask

    initial begin
        step();
        test_reset();
        test_init_wrap();
        test_mid_reset();
        test_width1();
        test_top_value();
        test_long_run();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_cycle_counter.md
BSG_CYCLE_COUNTER -- requirements
Module: bsg_cycle_counter

Interface
REQ-001 The block SHALL have parameter width_p, default 32, counter width in bits; legal range 1..64.
REQ-002 The block SHALL have parameter init_val_p, default 0, value loaded on reset; only its low width_p bits are used.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port ctr_r_o, output, width_p bits: registered current count.
REQ-006 The block SHALL have port overflow_o, output, 1 bit: registered sticky flag, set once the count has wrapped (or saturated).
REQ-007 All outputs SHALL be driven directly from flops, with no combinational path from any input.

Function
REQ-008 On each rising edge with reset_n_i=1, ctr_r_o SHALL update to ctr_r_o+1, modulo 2^width_p.
REQ-009 Increment latency SHALL be exactly one cycle: the value is visible immediately after the edge that produced it.
REQ-010 Wrap: on an edge where ctr_r_o is all-ones, ctr_r_o SHALL become 0 and overflow_o SHALL become 1 on that same edge.
REQ-011 overflow_o SHALL remain 1 until reset and SHALL NOT clear on later wraps.
REQ-012 Increment arithmetic SHALL be width_p bits wide; the carry-out SHALL be used only for overflow detection.
REQ-013 width_p=1: ctr_r_o SHALL toggle every cycle, and overflow_o SHALL set on the first 1->0 transition.
REQ-014 If init_val_p is all-ones, overflow_o SHALL set on the first edge after reset release.
REQ-015 There SHALL be no enable or hold; the counter counts every non-reset cycle.

Reset
REQ-016 On a rising edge with reset_n_i=0, ctr_r_o SHALL load init_val_p[width_p-1:0] and overflow_o SHALL load 0.
REQ-017 Reset SHALL take precedence over increment, wrap and saturation on the same edge.
REQ-018 Reset asserted mid-count SHALL override the count on the next edge, with no partial update.
REQ-019 Reset SHALL have no asynchronous effect: outputs change only on clk_i rising edges.
REQ-020 While reset_n_i stays 0, ctr_r_o SHALL hold init_val_p.
REQ-021 On the first edge with reset_n_i=1, ctr_r_o SHALL become init_val_p+1.

Configuration
REQ-022 The configuration macro SHALL be BSG_CYCLE_COUNTER_SATURATE_EN.
REQ-023 Macro undefined: wrap-around behaviour SHALL apply as REQ-010.
REQ-024 Macro defined: at all-ones the counter SHALL hold all-ones instead of wrapping.
REQ-025 Macro defined: overflow_o SHALL set on the first edge on which an increment is attempted at all-ones.
REQ-026 Macro defined: reset SHALL behave identically to the macro-undefined build.

Verification
REQ-027 Reset and count: width_p=8, init_val_p=0; hold reset_n_i=0 for 3 edges, then release -> ctr_r_o holds 0 during reset, then reads 1,2,3 on successive edges.
REQ-028 Nonzero init: width_p=8, init_val_p=8'hFD; release reset -> ctr_r_o reads FE, FF, 00, 01; overflow_o becomes 1 together with 00 and stays 1.
REQ-029 Mid-count reset: width_p=4; count to 9, then assert reset_n_i=0 for one edge -> ctr_r_o=0 and overflow_o=0 after that edge; counting resumes at 1.
REQ-030 Width 1: width_p=1, init_val_p=0 -> ctr_r_o reads 1,0,1,0; overflow_o sets on the first 0.
REQ-031 Saturate build (BSG_CYCLE_COUNTER_SATURATE_EN defined): width_p=4, init_val_p=4'hE -> ctr_r_o reads F, F, F; overflow_o sets on the second edge after release and stays 1.
REQ-032 Long run: width_p=16, run 70000 cycles -> ctr_r_o = (70000 mod 65536) = 4464 relative to init 0, with overflow_o=1.
